// File: rtl/bram_cfg_pkg.sv
// Shared width-mode encodings and lane helpers
// for the configurable BRAM / FIFO tile.
package bram_cfg_pkg;

  localparam int MAX_DW = 256;

  typedef enum logic [1:0] {
    WMODE_FULL    = 2'd0,
    WMODE_HALF    = 2'd1,
    WMODE_QUARTER = 2'd2,
    WMODE_RSVD    = 2'd3
  } wmode_e;

  typedef struct packed {
    wmode_e     mode;
    logic [1:0] sub;
  } rsel_t;

  function automatic wmode_e to_wmode(
    input logic [1:0] sel
  );
    unique case (sel)
      2'd1:    return WMODE_HALF;
      2'd2:    return WMODE_QUARTER;
      default: return WMODE_FULL;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(
    input wmode_e     mode,
    input logic [1:0] sub
  );
    unique case (mode)
      WMODE_HALF:    return sub[0] ? 4'b1100 : 4'b0011;
      WMODE_QUARTER: return 4'b0001 << sub;
      default:       return 4'b1111;
    endcase
  endfunction

  // lw is the lane width in bits; result is right-aligned and zero-filled
  function automatic logic [MAX_DW-1:0] rd_extract(
    input wmode_e            mode,
    input logic [1:0]        sub,
    input logic [MAX_DW-1:0] word,
    input int                lw
  );
    logic [MAX_DW-1:0] s;
    int keep;
    int lo;
    keep = 4;
    lo   = 0;
    unique case (mode)
      WMODE_HALF: begin
        keep = 2;
        lo   = sub[0] ? 2 : 0;
      end
      WMODE_QUARTER: begin
        keep = 1;
        lo   = int'(sub);
      end
      default: begin
        keep = 4;
        lo   = 0;
      end
    endcase
    s = word >> (lo * lw);
    for (int i = 0; i < MAX_DW; i++) begin
      if (i >= keep * lw) s[i] = 1'b0;
    end
    return s;
  endfunction

endpackage

// File: rtl/bram_sdp_core.sv
// Behavioural simple dual-port array with a
// 4-lane write mask and a read-first registered read.
module bram_sdp_core
  import bram_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [3:0]            wmask,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int LW    = DATA_WIDTH / 4;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // lane-masked write; contents are never reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < 4; l++) begin
        if (wmask[l]) begin
          mem[waddr][l*LW +: LW] <= wdata[l*LW +: LW];
        end
      end
    end
  end

  // read register samples the pre-write word (read-first)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/bram_sdp_fifo_cfg.sv
// Configurable BRAM tile: aspect-ratio steering,
// synchronous FIFO mode and optional output register.
module bram_sdp_fifo_cfg
  import bram_cfg_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int AFULL_LEVEL  = (2**ADDR_WIDTH) - 4,
  parameter int AEMPTY_LEVEL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH+1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH+1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic [1:0]            wr_width_sel,
  input  logic [1:0]            rd_width_sel,
  input  logic                  out_reg_en,
  input  logic                  fifo_mode,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int LW    = DATA_WIDTH / 4;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_LEVEL);

  logic                  mode_q;
  logic                  mode_chg;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [CW-1:0]         cnt_n;
  logic                  push_req;
  logic                  pop_req;
  logic                  push_ok;
  logic                  pop_ok;
  wmode_e                wm;
  wmode_e                rm;
  logic                  we;
  logic                  re;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [3:0]            wmask;
  logic [DATA_WIDTH-1:0] wdat_s;
  logic [DATA_WIDTH-1:0] q;
  logic [DATA_WIDTH-1:0] e1;
  logic [DATA_WIDTH-1:0] d2;
  rsel_t                 sel1;
  logic                  v1;
  logic                  v2;

  assign mode_chg = fifo_mode != mode_q;
  assign push_req = fifo_mode && !mode_chg && wr_en;
  assign pop_req  = fifo_mode && !mode_chg && rd_en;
  assign push_ok  = push_req && !full;
  assign pop_ok   = pop_req && !empty;

  assign wm = fifo_mode ? WMODE_FULL : to_wmode(wr_width_sel);
  assign rm = fifo_mode ? WMODE_FULL : to_wmode(rd_width_sel);

  assign we    = fifo_mode ? push_ok : wr_en;
  assign re    = fifo_mode ? pop_ok : rd_en;
  assign waddr = fifo_mode ? wptr : wr_addr[ADDR_WIDTH-1:0];
  assign raddr = fifo_mode ? rptr : rd_addr[ADDR_WIDTH-1:0];
  assign wmask = lane_mask(wm, wr_addr[ADDR_WIDTH+1:ADDR_WIDTH]);

  // replicate narrow write data so every lane sees the LSBs
  always_comb begin
    wdat_s = wr_data;
    unique case (wm)
      WMODE_HALF:    wdat_s = {2{wr_data[2*LW-1:0]}};
      WMODE_QUARTER: wdat_s = {4{wr_data[LW-1:0]}};
      default:       wdat_s = wr_data;
    endcase
  end

  bram_sdp_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wmask (wmask),
    .wdata (wdat_s),
    .re    (re),
    .raddr (raddr),
    .rdata (q)
  );

  // next occupancy; a mode switch empties the FIFO
  always_comb begin
    cnt_n = count;
    if (mode_chg) begin
      cnt_n = '0;
    end else if (push_ok && !pop_ok) begin
      cnt_n = count + 1'b1;
    end else if (pop_ok && !push_ok) begin
      cnt_n = count - 1'b1;
    end
  end

  // pointers, registered flags and sticky errors
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q    <= fifo_mode;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      mode_q <= fifo_mode;
      if (mode_chg) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push_ok) wptr <= wptr + 1'b1;
        if (pop_ok)  rptr <= rptr + 1'b1;
      end
      count  <= cnt_n;
      full   <= cnt_n == DEPTH_C;
      empty  <= cnt_n == '0;
      afull  <= cnt_n >= AF_C;
      aempty <= cnt_n <= AE_C;
      if (push_req && full)  overflow  <= 1'b1;
      if (pop_req && empty) underflow <= 1'b1;
    end
  end

  assign e1 = DATA_WIDTH'(rd_extract(sel1.mode, sel1.sub,
                                     MAX_DW'(q), LW));

  // read pipeline: select capture, valid tracking, output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      sel1 <= '{mode: WMODE_FULL, sub: 2'b00};
      d2   <= '0;
    end else begin
      v1 <= re;
      v2 <= v1;
      if (re) begin
        sel1 <= '{mode: rm,
                  sub:  rd_addr[ADDR_WIDTH+1:ADDR_WIDTH]};
      end
      if (v1) d2 <= e1;
    end
  end

  assign rd_data  = out_reg_en ? d2 : e1;
  assign rd_valid = out_reg_en ? v2 : v1;

endmodule

// File: doc/bram_sdp_fifo_cfg.md
Name: bram_sdp_fifo_cfg

Overview:
- Parametrised successor to the fixed 1 KB fabric block RAM. Depth, width and lane count are set by parameters, and the block uses a behavioural memory array instead of a hard macro.
- Keeps the configurable write/read port aspect ratios and the optional output register.
- Adds read enable, a read-valid strobe, defined read-during-write behaviour, and a synchronous FIFO mode with flags.
- Sits in the BRAM tile and is driven by fabric routing plus configuration bits.

Parameters:
- DATA_WIDTH, 32, full word width; must be a multiple of 4.
- ADDR_WIDTH, 8, word address width; DEPTH = 2**ADDR_WIDTH.
- AFULL_LEVEL, DEPTH-4, count at or above which afull asserts.
- AEMPTY_LEVEL, 4, count at or below which aempty asserts.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- wr_en  in  1  write request (RAM) / push (FIFO).
- wr_addr  in  ADDR_WIDTH+2  [ADDR_WIDTH-1:0] word index; [ADDR_WIDTH+1:ADDR_WIDTH] sub-word select.
- wr_data  in  DATA_WIDTH  write data; narrow modes use the LSBs.
- rd_en  in  1  read request (RAM) / pop (FIFO).
- rd_addr  in  ADDR_WIDTH+2  same layout as wr_addr.
- rd_data  out  DATA_WIDTH  read data; narrow modes drive the LSBs and zero the upper bits.
- rd_valid  out  1  rd_data is valid this cycle.
- wr_width_sel  in  2  0 full, 1 half, 2 quarter, 3 treated as full.
- rd_width_sel  in  2  same encoding as wr_width_sel.
- out_reg_en  in  1  adds one output register stage.
- fifo_mode  in  1  1 = FIFO, 0 = simple dual-port RAM.
- full, empty, afull, aempty  out  1 each  FIFO flags.
- count  out  ADDR_WIDTH+1  FIFO occupancy, 0..DEPTH.
- overflow, underflow  out  1 each  sticky FIFO error flags.

Behaviour:
- Reset (rst_n low at the edge):
  - rd_data=0, rd_valid=0, full=0, empty=1, afull=0, aempty=1, count=0, overflow=0, underflow=0.
  - Pointers and the output pipeline are cleared.
  - Memory contents are not reset.
  - Reset arriving mid-operation discards any in-flight read, so rd_valid=0 on the next cycle.
- RAM mode, write:
  - On wr_en, the lane mask is derived from wr_width_sel and wr_addr MSBs. Full: all lanes. Half: sub-word bit0 selects the low or high half. Quarter: sub-word selects one quarter.
  - The LSBs of wr_data are steered into the selected lane(s).
  - Unselected lanes are not modified.
- RAM mode, read:
  - Read latency is 1 cycle after rd_en, or 2 cycles when out_reg_en=1.
  - rd_valid pulses exactly once per accepted rd_en, aligned with rd_data.
  - Sub-word select and rd_width_sel are captured together with the address at the rd_en edge, and applied to the array output when it returns.
  - Read-during-write to the same word in the same cycle is read-first: the old data is returned.
  - rd_data holds its last value while rd_valid=0.
- FIFO mode: full width only; wr_width_sel and rd_width_sel are ignored; address ports are ignored.
  - Push is accepted when wr_en && !full. It writes at wptr, and wptr increments with wrap at DEPTH.
  - Pop is accepted when rd_en && !empty. It reads at rptr, and rptr increments with wrap.
  - Data and rd_valid follow the same latency as RAM mode.
  - Push while full is dropped and sets overflow. This holds even if a pop occurs in the same cycle.
  - Pop while empty is dropped and sets underflow. A push in the same cycle does not rescue it.
  - Simultaneous accepted push and pop leaves count unchanged.
  - count, full (count==DEPTH), empty (count==0), afull and aempty are all registered and updated in the same cycle as the pointers.
  - overflow and underflow stay set until reset.
- Mode switch:
  - Any cycle in which fifo_mode differs from its registered copy clears the pointers and count, and forces empty=1.
  - In-flight reads still complete.
- The out_reg_en and width selects are static configuration. Changing them while reads are in flight gives undefined data, but rd_valid stays correct.

Decomposition:
- Package bram_cfg_pkg:
  - Width-mode encodings WMODE_FULL, WMODE_HALF, WMODE_QUARTER.
  - Lane-mask function (mode, subword) -> 4-bit mask.
  - Read-extract function (mode, subword, word) -> data.
- Sub-module bram_sdp_core: behavioural DEPTH x DATA_WIDTH array with a 4-lane write mask and a registered, read-first read port.
- The top level contains steering, FIFO pointers/flags and the output pipeline.

Test Plan:
- RAM full width: write 0xDEADBEEF @5, rd_en @5 -> rd_valid and 0xDEADBEEF on cycle +1; with out_reg_en=1, on cycle +2.
- Quarter write: write 0x11, 0x22, 0x33, 0x44 @7 with subwords 0..3 (0x44 is subword 3) -> full read @7 = 0x44332211. Then a half read with subword 1 -> 0x00004433.
- Read-during-write: word @3 = 0xAAAA0000; write 0x12345678 @3 and read @3 in the same cycle -> 0xAAAA0000 returned; the next read returns 0x12345678.
- FIFO fill: DEPTH=256; push 0..255 -> full=1 and count=256. Push a 257th word -> dropped, overflow=1. Pop all -> data 0..255 in order, empty=1. One further pop -> underflow=1.
- FIFO push+pop: simultaneous push+pop at count=10 -> count stays 10. Simultaneous push+pop when empty -> only the push is accepted, count=1, underflow=1.
- Reset with a read in flight (out_reg_en=1): rd_n low the cycle after rd_en -> rd_valid never asserts, all flags return to their reset values, and count=0.
